// File: rtl/modbus_rtu_pkg.sv
// Shared Modbus RTU timing definitions: FSM states and silence-threshold arithmetic.
package modbus_rtu_pkg;

   typedef enum logic [1:0] {
      STARTUP,
      IDLE,
      FRAME,
      GAP
   } gap_state_e;

   localparam longint unsigned FIXED_T15_US     = 64'd750;
   localparam longint unsigned FIXED_T35_US     = 64'd1750;
   localparam longint unsigned FIXED_BAUD_LIMIT = 64'd19200;

   // Ceil of a silence length in clock cycles; mult_x2 is 3 for t1.5 and 7 for t3.5.
   // Above the baud limit Modbus fixes the silences to 750 us / 1750 us.
   function automatic longint unsigned gap_cycles(
      input longint unsigned clk_freq,
      input longint unsigned baud,
      input longint unsigned char_bits,
      input longint unsigned mult_x2
   );
      longint unsigned num;
      longint unsigned den;
      if (baud > FIXED_BAUD_LIMIT) begin
         num = clk_freq * ((mult_x2 <= 64'd3) ? FIXED_T15_US : FIXED_T35_US);
         den = 64'd1000000;
      end else begin
         num = clk_freq * char_bits * mult_x2;
         den = 64'd2 * baud;
      end
      return (num + den - 64'd1) / den;
   endfunction

endpackage

// File: rtl/modbus_frame_gap_timer_if.sv
// Byte-event and frame-status bundle between the UART receiver side and the frame assembler side.
interface modbus_frame_gap_timer_if #(
   parameter int unsigned MAX_FRAME = 256
);
   logic                               rx_done;
   logic                               rx_err;
   logic                               rx_new_frame;
   logic                               frame_end;
   logic                               frame_err;
   logic [$clog2(MAX_FRAME + 1)-1:0]   byte_cnt;
   logic                               line_idle;

   modport master (
      output rx_done, rx_err,
      input  rx_new_frame, frame_end, frame_err, byte_cnt, line_idle
   );

   modport slave (
      input  rx_done, rx_err,
      output rx_new_frame, frame_end, frame_err, byte_cnt, line_idle
   );
endinterface

// File: rtl/modbus_frame_gap_timer_gap.sv
// Silence counter: clears on a byte, otherwise counts up and saturates at MAX.
// Latency: compares are combinational from the count register.
// Backpressure: none; every clear is taken the cycle it arrives.
module gap_counter #(
   parameter int unsigned MAX = 4011,
   parameter int unsigned T15 = 1719
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clr,
   output logic ge_t15,
   output logic at_t35
);
   localparam int unsigned W = $clog2(MAX + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (cnt != W'(MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // cnt+1 is the silence length that the current cycle completes, so the
   // compares fire on the cycle the threshold is reached, not one later.
   assign ge_t15 = (cnt >= W'(T15 - 1));
   assign at_t35 = (cnt >= W'(MAX - 1));

endmodule

// File: rtl/modbus_frame_gap_timer.sv
// Modbus RTU t1.5/t3.5 silence tracker: frame start/end, inter-character violation, byte count.
// Latency: all outputs registered, one cycle after the rx_done that causes them.
// Backpressure: none; rx_done is a strobe and is always consumed.
module modbus_frame_gap_timer
   import modbus_rtu_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned CHAR_BITS = 11,
   parameter int unsigned MAX_FRAME = 256
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   modbus_frame_gap_timer_if.slave  bus
);
   localparam longint unsigned T15_CYC =
      gap_cycles(64'(CLK_FREQ), 64'(BAUD_RATE), 64'(CHAR_BITS), 64'd3);
   localparam longint unsigned T35_CYC =
      gap_cycles(64'(CLK_FREQ), 64'(BAUD_RATE), 64'(CHAR_BITS), 64'd7);
   localparam int unsigned T15 = 32'(T15_CYC);
   localparam int unsigned T35 = 32'(T35_CYC);
   localparam int unsigned CW  = $clog2(MAX_FRAME + 1);

   gap_state_e    state_q, state_d;
   logic          ge_t15, at_t35, late;
   logic          new_frame_q, new_frame_d;
   logic          frame_end_q, frame_end_d;
   logic          frame_err_q, frame_err_d;
   logic          line_idle_q;
   logic [CW-1:0] byte_cnt_q, byte_cnt_d;

   gap_counter #(
      .MAX (T35),
      .T15 (T15)
   ) u_gap (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clr    (bus.rx_done),
      .ge_t15 (ge_t15),
      .at_t35 (at_t35)
   );

   always_comb begin
      state_d     = state_q;
      new_frame_d = 1'b0;
      frame_end_d = 1'b0;
      frame_err_d = frame_err_q;
      byte_cnt_d  = byte_cnt_q;
      late        = 1'b0;
      case (state_q)
         STARTUP: begin
            if (!bus.rx_done && at_t35) state_d = IDLE;
         end
         IDLE: begin
            if (bus.rx_done) begin
               new_frame_d = 1'b1;
               byte_cnt_d  = CW'(1);
               frame_err_d = bus.rx_err;
               state_d     = FRAME;
            end
         end
         FRAME, GAP: begin
            // A byte on the very cycle silence reaches t1.5 is already late,
            // although GAP only becomes the registered state one cycle later.
            late = (state_q == GAP) || ge_t15;
            if (bus.rx_done) begin
               state_d = FRAME;
               if (byte_cnt_q == CW'(MAX_FRAME)) frame_err_d = 1'b1;
               else                              byte_cnt_d  = byte_cnt_q + 1'b1;
               if (late || bus.rx_err) frame_err_d = 1'b1;
            end else if ((state_q == GAP) && at_t35) begin
               frame_end_d = 1'b1;
               state_d     = IDLE;
            end else if ((state_q == FRAME) && ge_t15) begin
               state_d = GAP;
            end
         end
         default: state_d = STARTUP;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= STARTUP;
         new_frame_q <= 1'b0;
         frame_end_q <= 1'b0;
         frame_err_q <= 1'b0;
         byte_cnt_q  <= '0;
         line_idle_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         new_frame_q <= new_frame_d;
         frame_end_q <= frame_end_d;
         frame_err_q <= frame_err_d;
         byte_cnt_q  <= byte_cnt_d;
         line_idle_q <= (state_d == IDLE);
      end
   end

   assign bus.rx_new_frame = new_frame_q;
   assign bus.frame_end    = frame_end_q;
   assign bus.frame_err    = frame_err_q;
   assign bus.byte_cnt     = byte_cnt_q;
   assign bus.line_idle    = line_idle_q;

endmodule

// File: tb/tb_modbus_frame_gap_timer.sv
// Bench: three configurations driven with the same byte stream, each tracked by an elapsed-time reference model.
module tb_modbus_frame_gap_timer;
   localparam int NDUT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   modbus_frame_gap_timer_if #(.MAX_FRAME(256)) if_a ();
   modbus_frame_gap_timer_if #(.MAX_FRAME(256)) if_b ();
   modbus_frame_gap_timer_if #(.MAX_FRAME(4))   if_c ();

   modbus_frame_gap_timer #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .CHAR_BITS(11), .MAX_FRAME(256))
      dut_a (.clk_in(clk), .rst_in(rst), .bus(if_a.slave));
   modbus_frame_gap_timer #(.CLK_FREQ(1000000), .BAUD_RATE(38400), .CHAR_BITS(11), .MAX_FRAME(256))
      dut_b (.clk_in(clk), .rst_in(rst), .bus(if_b.slave));
   modbus_frame_gap_timer #(.CLK_FREQ(1000000), .BAUD_RATE(38400), .CHAR_BITS(11), .MAX_FRAME(4))
      dut_c (.clk_in(clk), .rst_in(rst), .bus(if_c.slave));

   // Thresholds worked out by hand: 1e6*11*3/19200 = 1718.75 -> 1719, *7 -> 4010.4 -> 4011; 38400 uses 750/1750 us.
   int t15  [NDUT] = '{1719, 750, 750};
   int t35  [NDUT] = '{4011, 1750, 1750};
   int maxf [NDUT] = '{256, 256, 4};

   logic       o_new [NDUT];
   logic       o_fend[NDUT];
   logic       o_err [NDUT];
   logic       o_idle[NDUT];
   logic [8:0] o_bc  [NDUT];

   always_comb begin
      o_new[0] = if_a.rx_new_frame; o_fend[0] = if_a.frame_end; o_err[0] = if_a.frame_err;
      o_idle[0] = if_a.line_idle;   o_bc[0] = 9'(if_a.byte_cnt);
      o_new[1] = if_b.rx_new_frame; o_fend[1] = if_b.frame_end; o_err[1] = if_b.frame_err;
      o_idle[1] = if_b.line_idle;   o_bc[1] = 9'(if_b.byte_cnt);
      o_new[2] = if_c.rx_new_frame; o_fend[2] = if_c.frame_end; o_err[2] = if_c.frame_err;
      o_idle[2] = if_c.line_idle;   o_bc[2] = 9'(if_c.byte_cnt);
   end

   // Reference model: silence is edge_n minus the edge of the last byte (or of reset release).
   int edge_n;
   int m_last[NDUT], m_cnt[NDUT], mdl_new_cnt[NDUT], mdl_fend_cnt[NDUT];
   bit m_started[NDUT], m_inframe[NDUT], m_err[NDUT], m_new[NDUT], m_fend[NDUT];

   // Monitor records (edges are numbered from reset release; sampling is #1 after the edge).
   int dut_new_cnt[NDUT], dut_new_edge[NDUT], dut_fend_cnt[NDUT], dut_fend_edge[NDUT];
   int dut_fend_bc[NDUT], trace_bad[NDUT];
   bit dut_fend_err[NDUT];

   int errors = 0;
   int checks = 0;

   task automatic drive(input bit d, input bit e);
      if_a.rx_done = d; if_a.rx_err = e;
      if_b.rx_done = d; if_b.rx_err = e;
      if_c.rx_done = d; if_c.rx_err = e;
   endtask

   task automatic model_reset();
      edge_n = 0;
      for (int i = 0; i < NDUT; i++) begin
         m_last[i] = 0; m_cnt[i] = 0; m_started[i] = 0; m_inframe[i] = 0;
         m_err[i] = 0; m_new[i] = 0; m_fend[i] = 0;
      end
   endtask

   task automatic model_edge(input bit d, input bit e);
      for (int i = 0; i < NDUT; i++) begin
         int s;
         s = edge_n - m_last[i];
         m_new[i] = 0;
         m_fend[i] = 0;
         if (!m_started[i]) begin
            if (d) m_last[i] = edge_n;
            else if (s >= t35[i]) m_started[i] = 1;
         end else if (!m_inframe[i]) begin
            if (d) begin
               m_new[i] = 1; m_cnt[i] = 1; m_err[i] = e; m_inframe[i] = 1; m_last[i] = edge_n;
               mdl_new_cnt[i]++;
            end
         end else if (d) begin
            if (m_cnt[i] >= maxf[i]) m_err[i] = 1;
            else m_cnt[i]++;
            if (s >= t15[i] || e) m_err[i] = 1;
            m_last[i] = edge_n;
         end else if (s >= t35[i]) begin
            m_fend[i] = 1; m_inframe[i] = 0;
            mdl_fend_cnt[i]++;
         end
      end
   endtask

   task automatic step(input bit d, input bit e);
      drive(d, e);
      @(posedge clk);
      edge_n++;
      model_edge(d, e);
      #1;
      for (int i = 0; i < NDUT; i++) begin
         if (o_new[i] !== m_new[i] || o_fend[i] !== m_fend[i] || o_err[i] !== m_err[i] ||
             o_bc[i] !== 9'(m_cnt[i]) || o_idle[i] !== (m_started[i] && !m_inframe[i]))
            trace_bad[i]++;
         if (o_new[i] === 1'b1) begin
            dut_new_cnt[i]++; dut_new_edge[i] = edge_n;
         end
         if (o_fend[i] === 1'b1) begin
            dut_fend_cnt[i]++; dut_fend_edge[i] = edge_n;
            dut_fend_err[i] = o_err[i]; dut_fend_bc[i] = int'(o_bc[i]);
         end
      end
   endtask

   task automatic silence(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   // Next byte lands exactly gap edges after the previous step.
   task automatic send_gap(input int gap, input bit e);
      silence(gap - 1);
      step(1'b1, e);
   endtask

   task automatic clear_obs();
      for (int i = 0; i < NDUT; i++) begin
         dut_new_cnt[i] = 0; dut_new_edge[i] = -1; dut_fend_cnt[i] = 0; dut_fend_edge[i] = -1;
         dut_fend_bc[i] = -1; dut_fend_err[i] = 0; trace_bad[i] = 0;
         mdl_new_cnt[i] = 0; mdl_fend_cnt[i] = 0;
      end
   endtask

   task automatic check_trace(input string name);
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if (trace_bad[i] !== 0) begin
            errors++;
            $display("FAIL %s trace dut=%0d got %0d bad cycles, want 0", name, i, trace_bad[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if ({o_new[i], o_fend[i], o_err[i], o_idle[i]} !== 4'b0 || o_bc[i] !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs dut=%0d got new=%b end=%b err=%b idle=%b cnt=%0d, want all 0",
                     i, o_new[i], o_fend[i], o_err[i], o_idle[i], o_bc[i]);
         end
      end
      rst = 1'b0;
      model_reset();
      clear_obs();
      silence(4010);
      checks++;
      if (o_idle[0] !== 1'b0) begin
         errors++; $display("FAIL reset_idle_early got %b want 0", o_idle[0]);
      end
      checks++;
      if (o_idle[1] !== 1'b1) begin
         errors++; $display("FAIL reset_idle_fast got %b want 1", o_idle[1]);
      end
      step(1'b0, 1'b0);
      checks++;
      if (o_idle[0] !== 1'b1) begin
         errors++; $display("FAIL reset_idle_t35 got %b want 1", o_idle[0]);
      end
      check_trace("reset");
   endtask

   task automatic test_basic_frame();
      int first, last;
      clear_obs();
      step(1'b1, 1'b0);
      first = edge_n;
      repeat (7) send_gap(1000, 1'b0);
      last = edge_n;
      silence(4011);
      checks++;
      if (dut_new_cnt[0] !== 1 || dut_new_edge[0] !== first) begin
         errors++; $display("FAIL basic_new got cnt=%0d edge=%0d want 1 at %0d", dut_new_cnt[0], dut_new_edge[0], first);
      end
      // Sampled right after edge N+T35, i.e. the pulse occupies cycle N+T35+1.
      checks++;
      if (dut_fend_cnt[0] !== 1 || dut_fend_edge[0] - last !== 4011) begin
         errors++; $display("FAIL basic_end got cnt=%0d delta=%0d want 1 and 4011", dut_fend_cnt[0], dut_fend_edge[0] - last);
      end
      checks++;
      if (dut_fend_bc[0] !== 8 || dut_fend_err[0] !== 1'b0) begin
         errors++; $display("FAIL basic_status got bc=%0d err=%b want 8 0", dut_fend_bc[0], dut_fend_err[0]);
      end
      checks++;
      if (dut_fend_bc[1] !== 8 || dut_fend_err[1] !== 1'b1) begin
         errors++; $display("FAIL basic_fast_late got bc=%0d err=%b want 8 1", dut_fend_bc[1], dut_fend_err[1]);
      end
      checks++;
      if (dut_fend_bc[2] !== 4 || dut_fend_err[2] !== 1'b1) begin
         errors++; $display("FAIL basic_max4 got bc=%0d err=%b want 4 1", dut_fend_bc[2], dut_fend_err[2]);
      end
      check_trace("basic");
   endtask

   task automatic test_intra_gap();
      int last;
      clear_obs();
      step(1'b1, 1'b0);
      send_gap(1718, 1'b0);
      checks++;
      if (o_err[0] !== 1'b0 || o_bc[0] !== 9'd2) begin
         errors++; $display("FAIL gap1718 got err=%b bc=%0d want 0 2", o_err[0], o_bc[0]);
      end
      send_gap(1719, 1'b0);
      last = edge_n;
      checks++;
      if (o_err[0] !== 1'b1 || o_bc[0] !== 9'd3) begin
         errors++; $display("FAIL gap1719 got err=%b bc=%0d want 1 3", o_err[0], o_bc[0]);
      end
      silence(4011);
      checks++;
      if (dut_fend_cnt[0] !== 1 || dut_fend_err[0] !== 1'b1 || dut_fend_bc[0] !== 3 || dut_fend_edge[0] - last !== 4011) begin
         errors++; $display("FAIL gap_end got cnt=%0d err=%b bc=%0d delta=%0d want 1 1 3 4011",
                            dut_fend_cnt[0], dut_fend_err[0], dut_fend_bc[0], dut_fend_edge[0] - last);
      end
      check_trace("intra_gap");
   endtask

   task automatic test_fixed_time();
      int last;
      clear_obs();
      step(1'b1, 1'b0);
      send_gap(749, 1'b0);
      checks++;
      if (o_err[1] !== 1'b0 || o_bc[1] !== 9'd2) begin
         errors++; $display("FAIL fixed749 got err=%b bc=%0d want 0 2", o_err[1], o_bc[1]);
      end
      send_gap(750, 1'b0);
      last = edge_n;
      checks++;
      if (o_err[1] !== 1'b1 || o_bc[1] !== 9'd3) begin
         errors++; $display("FAIL fixed750 got err=%b bc=%0d want 1 3", o_err[1], o_bc[1]);
      end
      silence(1750);
      checks++;
      if (dut_fend_cnt[1] !== 1 || dut_fend_edge[1] - last !== 1750) begin
         errors++; $display("FAIL fixed_end got cnt=%0d delta=%0d want 1 1750", dut_fend_cnt[1], dut_fend_edge[1] - last);
      end
      silence(4011 - 1750);
      checks++;
      if (dut_fend_err[0] !== 1'b0 || dut_fend_bc[0] !== 3) begin
         errors++; $display("FAIL fixed_slow got err=%b bc=%0d want 0 3", dut_fend_err[0], dut_fend_bc[0]);
      end
      check_trace("fixed_time");
   endtask

   task automatic test_startup();
      rst = 1'b1;
      drive(1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      clear_obs();
      step(1'b1, 1'b0);
      repeat (2) send_gap(3000, 1'b0);
      silence(4010);
      checks++;
      if (o_idle[0] !== 1'b0) begin
         errors++; $display("FAIL startup_idle_early got %b want 0", o_idle[0]);
      end
      step(1'b0, 1'b0);
      checks++;
      if (o_idle[0] !== 1'b1) begin
         errors++; $display("FAIL startup_idle got %b want 1", o_idle[0]);
      end
      checks++;
      if (dut_new_cnt[0] !== 0 || dut_fend_cnt[0] !== 0 || o_bc[0] !== 9'd0) begin
         errors++; $display("FAIL startup_discard got new=%0d end=%0d bc=%0d want 0 0 0",
                            dut_new_cnt[0], dut_fend_cnt[0], o_bc[0]);
      end
      check_trace("startup");
   endtask

   task automatic test_overflow_and_err();
      clear_obs();
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      send_gap(99, 1'b0);
      repeat (4) send_gap(100, 1'b0);
      silence(4011);
      checks++;
      if (dut_fend_bc[2] !== 4 || dut_fend_err[2] !== 1'b1) begin
         errors++; $display("FAIL overflow got bc=%0d err=%b want 4 1", dut_fend_bc[2], dut_fend_err[2]);
      end
      checks++;
      if (dut_fend_bc[0] !== 6 || dut_fend_err[0] !== 1'b0) begin
         errors++; $display("FAIL lone_rx_err got bc=%0d err=%b want 6 0", dut_fend_bc[0], dut_fend_err[0]);
      end
      clear_obs();
      step(1'b1, 1'b0);
      send_gap(100, 1'b1);
      checks++;
      if (o_err[0] !== 1'b1) begin
         errors++; $display("FAIL rx_err_byte2 got %b want 1", o_err[0]);
      end
      send_gap(100, 1'b0);
      silence(4011);
      checks++;
      if (dut_fend_bc[0] !== 3 || dut_fend_err[0] !== 1'b1) begin
         errors++; $display("FAIL rx_err_end got bc=%0d err=%b want 3 1", dut_fend_bc[0], dut_fend_err[0]);
      end
      check_trace("overflow_err");
   endtask

   task automatic test_collision();
      int second;
      clear_obs();
      step(1'b1, 1'b0);
      send_gap(4011, 1'b0);
      second = edge_n;
      checks++;
      if (o_fend[0] !== 1'b0 || o_err[0] !== 1'b1 || o_bc[0] !== 9'd2 || dut_new_cnt[0] !== 1) begin
         errors++; $display("FAIL collision got end=%b err=%b bc=%0d new=%0d want 0 1 2 1",
                            o_fend[0], o_err[0], o_bc[0], dut_new_cnt[0]);
      end
      silence(4010);
      checks++;
      if (dut_fend_cnt[0] !== 0) begin
         errors++; $display("FAIL collision_early_end got %0d want 0", dut_fend_cnt[0]);
      end
      step(1'b0, 1'b0);
      checks++;
      if (dut_fend_cnt[0] !== 1 || dut_fend_edge[0] - second !== 4011) begin
         errors++; $display("FAIL collision_restart got cnt=%0d delta=%0d want 1 4011", dut_fend_cnt[0], dut_fend_edge[0] - second);
      end
      check_trace("collision");
   endtask

   task automatic test_reset_midframe();
      clear_obs();
      step(1'b1, 1'b0);
      send_gap(100, 1'b0);
      drive(1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if ({o_new[i], o_fend[i], o_err[i], o_idle[i]} !== 4'b0 || o_bc[i] !== 9'd0) begin
            errors++; $display("FAIL midreset_outputs dut=%0d got new=%b end=%b err=%b idle=%b cnt=%0d want all 0",
                               i, o_new[i], o_fend[i], o_err[i], o_idle[i], o_bc[i]);
         end
      end
      rst = 1'b0;
      model_reset();
      step(1'b1, 1'b0);
      silence(4011);
      checks++;
      if (dut_new_cnt[0] !== 1 || dut_fend_cnt[0] !== 0 || o_idle[0] !== 1'b1) begin
         errors++; $display("FAIL midreset_startup got new=%0d end=%0d idle=%b want 1 0 1",
                            dut_new_cnt[0], dut_fend_cnt[0], o_idle[0]);
      end
      step(1'b1, 1'b0);
      checks++;
      if (o_new[0] !== 1'b1 || o_bc[0] !== 9'd1) begin
         errors++; $display("FAIL midreset_accept got new=%b bc=%0d want 1 1", o_new[0], o_bc[0]);
      end
      silence(4011);
      check_trace("reset_midframe");
   endtask

   task automatic test_random();
      for (int f = 0; f < 2; f++) begin
         int  nb, exp_bc, gap;
         bit  e, exp_err;
         clear_obs();
         nb = $urandom_range(2, 4);
         e = ($urandom_range(0, 3) == 0);
         step(1'b1, e);
         exp_err = e;
         exp_bc = 1;
         for (int b = 0; b < nb; b++) begin
            gap = $urandom_range(1, 1800);
            e = ($urandom_range(0, 3) == 0);
            send_gap(gap, e);
            exp_bc++;
            if (e || gap >= 1719) exp_err = 1;
         end
         silence(4011);
         checks++;
         if (dut_fend_bc[0] !== exp_bc || dut_fend_err[0] !== exp_err) begin
            errors++; $display("FAIL random%0d_status got bc=%0d err=%b want %0d %b",
                               f, dut_fend_bc[0], dut_fend_err[0], exp_bc, exp_err);
         end
         for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (dut_fend_cnt[i] !== mdl_fend_cnt[i] || dut_new_cnt[i] !== mdl_new_cnt[i]) begin
               errors++; $display("FAIL random%0d_events dut=%0d got new=%0d end=%0d want %0d %0d",
                                  f, i, dut_new_cnt[i], dut_fend_cnt[i], mdl_new_cnt[i], mdl_fend_cnt[i]);
            end
         end
         check_trace("random");
      end
   endtask

   initial begin
      drive(1'b0, 1'b0);
      test_reset();
      test_basic_frame();
      test_intra_gap();
      test_fixed_time();
      test_startup();
      test_overflow_and_err();
      test_collision();
      test_reset_midframe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
